alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer that time-shares one combinational `alu` instance between two requesters (port 0: branch-compare path, port 1: execute path). It arbitrates between the requesters and registers the winning operands and opcode onto the ALU inputs. It then captures the ALU result and flags, and returns them on a single response channel tagged with the requester id. It sits between the decode/execute control logic and the shared ALU in the PPU datapath.

## Interface
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_A`, `req0_B` / `req1_A`, `req1_B`  in  32  operands.
- `req0_Op` / `req1_Op`  in  4  ALU opcode, same encoding as `alu.Op`.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `alu_A`, `alu_B`  out  32  registered operands driven to `alu.A`/`alu.B`.
- `alu_Op`  out  4  registered opcode driven to `alu.Op`.
- `alu_Out`  in  32  from `alu.Out`.
- `alu_zero`, `alu_N`, `alu_C`, `alu_V`  in  1  from the ALU flag outputs.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_Out`  out  32  captured result.
- `rsp_zero`, `rsp_N`, `rsp_C`, `rsp_V`  out  1  captured flags.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - If no valid request, stay in IDLE.
  - Otherwise grant one requester. The winner's `reqN_ready` = 1, combinationally, in this cycle only.
  - At the clock edge: latch the winner's A/B/Op into `alu_A`/`alu_B`/`alu_Op`, latch the grant into the id register, and go to EXEC.
- **EXEC**
  - One cycle; the ALU output settles.
  - At the edge: capture `alu_Out` into `rsp_Out`, capture the flags, and go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - Hold all `rsp_*` outputs stable until `rsp_ready` = 1.
  - At the edge where `rsp_valid & rsp_ready` holds, go to IDLE.
- **Flag masking**
  - The ALU updates its flags only for Op 3, 8 and 9; for all other opcodes it holds stale values.
  - Therefore `rsp_zero`/`rsp_N`/`rsp_C`/`rsp_V` are captured from the ALU only when `alu_Op` is 3, 8 or 9. For every other opcode they are captured as 0.
- **Arbitration**
  - Both ready outputs are 0 outside IDLE. Requests stay pending, with valid held high and operands stable, until accepted.
  - Only one ready is ever high in a cycle.
  - With `RR_EN`=1, a 1-bit priority pointer `pri` (reset 0) selects the preferred port when both are valid. After any grant to port n, `pri` becomes ~n.
  - A single valid request wins regardless of `pri`.
  - With `RR_EN`=0, port 0 wins any conflict and `pri` is unused.
- **Opcodes**
  - All 16 values are passed through unmodified; no opcode is rejected.
  - Op 13–15 yield `rsp_Out` = 0, with flags masked to 0.
- **Reset values** (asynchronous on `rst_n` = 0, including mid-transaction; the in-flight operation is discarded)
  - state = IDLE, `pri` = 0.
  - `alu_A` = `alu_B` = 0, `alu_Op` = 4'b0000.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_Out` = 0, all `rsp_*` flags 0.
  - Both ready outputs = 0 while `rst_n` = 0.
- Only one transaction is in flight; there is no buffering.

## Timing
- Request accepted at edge k (ready = 1 in cycle k−1 → k). `alu_*` outputs are valid after k, response is captured at k+1, and `rsp_valid` = 1 from k+1 onward.
- Minimum latency from acceptance to response is 2 cycles.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with `rsp_ready` already high, then IDLE.
- `rsp_ready` held high gives 1 response per 3 cycles; back-pressure stretches RESP indefinitely.
- `alu_A`/`alu_B`/`alu_Op` remain at the last granted values while in RESP and IDLE; they change only on a grant edge.
- A request whose valid rises during EXEC or RESP is first seen in the next IDLE cycle.
- `rsp_valid` drops in the cycle after the handshake edge (IDLE).

## Test plan
- **Reset:** assert `rst_n` = 0 mid-EXEC with `req0_valid` = 1 → all outputs at reset values immediately; after release, the first grant goes to port 0.
- **Single add:** port 0, A = 5, B = 7, Op = 2 → `rsp_valid` 2 cycles after accept; `rsp_Out` = 12, `rsp_id` = 0, all flags 0 (masked).
- **Subtract flags:** port 1, A = 3, B = 3, Op = 3 → `rsp_Out` = 0, `rsp_zero` = 1, `rsp_id` = 1. Then A = 0x7FFFFFFF, B = 0xFFFFFFFF, Op = 3 → `rsp_Out` = 0x80000000, `rsp_N` = 1, `rsp_V` = 1.
- **Round-robin:** both ports valid continuously with `RR_EN` = 1 → grant order 0, 1, 0, 1; each accept 3 cycles apart; the ready outputs are never high together.
- **Fixed priority:** same stimulus with `RR_EN` = 0 → port 0 is granted every time and port 1 is starved until `req0_valid` = 0.
- **Back-pressure:** `rsp_ready` = 0 for 5 cycles during RESP with port 1 valid → `rsp_*` outputs held stable, no new grant; port 1 is accepted in the IDLE cycle after the handshake. Op 14 on port 1 → `rsp_Out` = 0, flags 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - time-shares one combinational ALU between two requesters
// Grants one request, registers operands onto the ALU, captures result and flags, returns a tagged response.
module alu_share_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [3:0]  req0_Op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [3:0]  req1_Op,
  output logic        req1_ready,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_Op,
  input  logic [31:0] alu_Out,
  input  logic        alu_zero,
  input  logic        alu_N,
  input  logic        alu_C,
  input  logic        alu_V,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_Out,
  output logic        rsp_zero,
  output logic        rsp_N,
  output logic        rsp_C,
  output logic        rsp_V
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;
  logic   pri;
  logic   grant_any;
  logic   grant_id;
  logic   flag_op;

  always_comb begin
    state_nx   = state;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_any = 1'b1;
          if (req0_valid && req1_valid)
            grant_id = RR_EN ? pri : 1'b0;
          else
            grant_id = req1_valid;
          // readies are gated so nothing is offered while reset is held
          req0_ready = rst_n & ~grant_id;
          req1_ready = rst_n & grant_id;
          state_nx   = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  // the ALU only refreshes its flags for these opcodes; others carry stale values
  assign flag_op = (alu_Op == 4'd3) || (alu_Op == 4'd8) || (alu_Op == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pri      <= 1'b0;
      alu_A    <= 32'd0;
      alu_B    <= 32'd0;
      alu_Op   <= 4'd0;
      rsp_id   <= 1'b0;
      rsp_Out  <= 32'd0;
      rsp_zero <= 1'b0;
      rsp_N    <= 1'b0;
      rsp_C    <= 1'b0;
      rsp_V    <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_any) begin
        alu_A  <= grant_id ? req1_A  : req0_A;
        alu_B  <= grant_id ? req1_B  : req0_B;
        alu_Op <= grant_id ? req1_Op : req0_Op;
        rsp_id <= grant_id;
        if (RR_EN) pri <= ~grant_id;
      end
      if (state == EXEC) begin
        rsp_Out  <= alu_Out;
        rsp_zero <= flag_op & alu_zero;
        rsp_N    <= flag_op & alu_N;
        rsp_C    <= flag_op & alu_C;
        rsp_V    <= flag_op & alu_V;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed self-checking bench for alu_share_arbiter
// A transaction-level model predicts readies, ALU operand registers and tagged responses every cycle.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0]  req0_Op, req1_Op;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_A, alu_B, alu_Out;
  logic [3:0]  alu_Op;
  logic        alu_zero, alu_N, alu_C, alu_V;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_Out;
  logic        rsp_zero, rsp_N, rsp_C, rsp_V;

  logic        f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic [31:0] f_alu_A, f_alu_B, f_alu_Out, f_rsp_Out;
  logic [3:0]  f_alu_Op;
  logic        f_rsp_valid, f_rsp_ready, f_rsp_id;
  logic        f_rsp_zero, f_rsp_N, f_rsp_C, f_rsp_V;

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_A(req0_A), .req0_B(req0_B), .req0_Op(req0_Op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_A(req1_A), .req1_B(req1_B), .req1_Op(req1_Op), .req1_ready(req1_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_Out(alu_Out),
    .alu_zero(alu_zero), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_Out(rsp_Out),
    .rsp_zero(rsp_zero), .rsp_N(rsp_N), .rsp_C(rsp_C), .rsp_V(rsp_V)
  );

  alu_share_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_A(32'd20), .req0_B(32'd22), .req0_Op(4'd2), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_A(32'd1), .req1_B(32'd1), .req1_Op(4'd2), .req1_ready(f_req1_ready),
    .alu_A(f_alu_A), .alu_B(f_alu_B), .alu_Op(f_alu_Op), .alu_Out(f_alu_Out),
    .alu_zero(1'b1), .alu_N(1'b1), .alu_C(1'b1), .alu_V(1'b1),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_Out(f_rsp_Out),
    .rsp_zero(f_rsp_zero), .rsp_N(f_rsp_N), .rsp_C(f_rsp_C), .rsp_V(f_rsp_V)
  );

  assign f_alu_Out = f_alu_A + f_alu_B;

  // reference ALU: returns {zero, N, C, V, Out}
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] s;
    logic        c, v;
    s = 33'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  s[31:0] = a & b;
      4'd1:  s[31:0] = a | b;
      4'd2, 4'd8: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[32];
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'd3, 4'd9: begin
        s = {1'b0, a} - {1'b0, b};
        c = (a >= b);
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'd4:  s[31:0] = a ^ b;
      4'd5:  s[31:0] = a << b[4:0];
      4'd6:  s[31:0] = a >> b[4:0];
      4'd7:  s[31:0] = $signed(a) >>> b[4:0];
      4'd10: s[31:0] = ~(a | b);
      4'd11: s[31:0] = {31'd0, $signed(a) < $signed(b)};
      4'd12: s[31:0] = b;
      default: s[31:0] = 32'd0;
    endcase
    return {(s[31:0] == 32'd0), s[31], c, v, s[31:0]};
  endfunction

  function automatic logic [35:0] exp_rsp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [35:0] r;
    r = alu_fn(a, b, op);
    if (!(op == 4'd3 || op == 4'd8 || op == 4'd9)) r[35:32] = 4'd0;
    return r;
  endfunction

  logic [3:0]  junk;
  logic [35:0] alu_r;
  always @(posedge clk) junk <= 4'($urandom);
  always_comb begin
    alu_r   = alu_fn(alu_A, alu_B, alu_Op);
    alu_Out = alu_r[31:0];
    if (alu_Op == 4'd3 || alu_Op == 4'd8 || alu_Op == 4'd9)
      {alu_zero, alu_N, alu_C, alu_V} = alu_r[35:32];
    else
      {alu_zero, alu_N, alu_C, alu_V} = junk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        m_pend = 1'b0, m_pri = 1'b0, m_id = 1'b0;
  logic [31:0] m_A = 32'd0, m_B = 32'd0;
  logic [3:0]  m_Op = 4'd0;
  logic [35:0] m_exp = 36'd0;
  int          m_gedge = 0;
  logic        acc0, acc1, hs, f_acc0, f_acc1, last_id;
  int          acc_edge = 0, hs_edge = 0;
  logic [31:0] cap_out;
  logic [3:0]  cap_flags;
  logic        cap_id;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_pri = 1'b0; m_A = 32'd0; m_B = 32'd0; m_Op = 4'd0;
  endtask

  task automatic tick();
    logic e_r0, e_r1, e_rv, id;
    @(negedge clk);
    e_r0 = rst_n && !m_pend && req0_valid && (!req1_valid || m_pri == 1'b0);
    e_r1 = rst_n && !m_pend && req1_valid && !e_r0;
    e_rv = m_pend && (cyc >= m_gedge + 1);
    chk("req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("alu_A", alu_A, m_A);
    chk("alu_B", alu_B, m_B);
    chk("alu_Op", 32'(alu_Op), 32'(m_Op));
    if (e_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_Out", rsp_Out, m_exp[31:0]);
      chk("rsp_flags", 32'({rsp_zero, rsp_N, rsp_C, rsp_V}), 32'(m_exp[35:32]));
    end
    f_acc0 = f_req0_ready;
    f_acc1 = f_req1_ready;
    acc0 = e_r0;
    acc1 = e_r1;
    hs = e_rv && rsp_ready;
    if (hs) begin
      m_pend    = 1'b0;
      hs_edge   = cyc + 1;
      cap_out   = rsp_Out;
      cap_flags = {rsp_zero, rsp_N, rsp_C, rsp_V};
      cap_id    = rsp_id;
    end
    if (e_r0 || e_r1) begin
      id       = e_r1;
      m_pend   = 1'b1;
      m_gedge  = cyc + 1;
      m_id     = id;
      m_pri    = ~id;
      m_A      = id ? req1_A : req0_A;
      m_B      = id ? req1_B : req0_B;
      m_Op     = id ? req1_Op : req0_Op;
      m_exp    = exp_rsp(m_A, m_B, m_Op);
      acc_edge = cyc + 1;
      last_id  = id;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_one(input logic port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n;
    if (port) begin req1_valid = 1'b1; req1_A = a; req1_B = b; req1_Op = op; end
    else      begin req0_valid = 1'b1; req0_A = a; req0_B = b; req0_Op = op; end
    rsp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(port ? acc1 : acc0) && n < 20);
    chk("accept_seen", 32'(port ? acc1 : acc0), 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!hs && n < 20);
    chk("handshake_seen", 32'(hs), 32'd1);
    chk("latency", 32'(hs_edge - acc_edge), 32'd2);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g_edge_prev;
    int f_cnt0, f_cnt1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_A = 32'd0; req0_B = 32'd0; req0_Op = 4'd0;
    req1_A = 32'd0; req1_B = 32'd0; req1_Op = 4'd0;
    rsp_ready = 1'b1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp_ready = 1'b1;
    g_edge_prev = 0;
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_Op", 32'(alu_Op), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_one(1'b0, 32'd5, 32'd7, 4'd2);
    chk("add_out", cap_out, 32'd12);
    chk("add_flags", 32'(cap_flags), 32'd0);
    chk("add_id", 32'(cap_id), 32'd0);

    run_one(1'b1, 32'd3, 32'd3, 4'd3);
    chk("sub_out", cap_out, 32'd0);
    chk("sub_zero", 32'(cap_flags[3]), 32'd1);
    chk("sub_id", 32'(cap_id), 32'd1);

    run_one(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd3);
    chk("ovf_out", cap_out, 32'h8000_0000);
    chk("ovf_N", 32'(cap_flags[2]), 32'd1);
    chk("ovf_V", 32'(cap_flags[0]), 32'd1);

    // reset in the middle of EXEC with port 0 still requesting
    req0_valid = 1'b1; req0_A = 32'hDEAD_BEEF; req0_B = 32'h1234_5678; req0_Op = 4'd4;
    n = 0;
    do begin tick(); n++; end while (!acc0 && n < 20);
    chk("pre_reset_accept", 32'(acc0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_reset_alu_A", alu_A, 32'd0);
    chk("mid_reset_alu_B", alu_B, 32'd0);
    chk("mid_reset_rsp_Out", rsp_Out, 32'd0);
    chk("mid_reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_reset_flags", 32'({rsp_zero, rsp_N, rsp_C, rsp_V}), 32'd0);
    chk("mid_reset_ready0", 32'(req0_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_A = 32'd100; req1_B = 32'd1; req1_Op = 4'd3;

    // round-robin with both ports requesting continuously
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin tick(); n++; end while (!(acc0 || acc1) && n < 20);
      chk("rr_accept_seen", 32'(acc0 || acc1), 32'd1);
      chk("rr_order", 32'(last_id), 32'(g % 2));
      if (g > 0) chk("rr_spacing", 32'(acc_edge - g_edge_prev), 32'd3);
      g_edge_prev = acc_edge;
      if (acc0) begin req0_A = $urandom; req0_B = $urandom; req0_Op = 4'($urandom); end
      else      begin req1_A = $urandom; req1_B = $urandom; req1_Op = 4'($urandom); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (m_pend && n < 20) begin tick(); n++; end

    // back-pressure while port 1 waits
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_A = 32'd9; req0_B = 32'd4; req0_Op = 4'd2;
    n = 0;
    do begin tick(); n++; end while (!acc0 && n < 20);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_A = 32'd123; req1_B = 32'd456; req1_Op = 4'd14;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_no_grant", 32'(req1_ready), 32'd0);
      chk("bp_hold_out", rsp_Out, 32'd13);
    end
    rsp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!hs && n < 20);
    tick();
    chk("bp_accept_port1", 32'(acc1), 32'd1);
    chk("bp_accept_edge", 32'(acc_edge - hs_edge), 32'd1);
    req1_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!hs && n < 20);
    chk("op14_out", cap_out, 32'd0);
    chk("op14_flags", 32'(cap_flags), 32'd0);
    chk("op14_id", 32'(cap_id), 32'd1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(1) == 0);
        req0_A = rnd_operand(); req0_B = rnd_operand(); req0_Op = 4'($urandom);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(1) == 0);
        req1_A = rnd_operand(); req1_B = rnd_operand(); req1_Op = 4'($urandom);
      end
      rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;

    // fixed-priority instance: port 1 starves while port 0 requests
    f_req0_valid = 1'b1;
    f_req1_valid = 1'b1;
    f_cnt0 = 0;
    f_cnt1 = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (f_acc0) f_cnt0++;
      if (f_acc1) f_cnt1++;
    end
    chk("fp_port0_grants", 32'(f_cnt0), 32'd5);
    chk("fp_port1_starved", 32'(f_cnt1), 32'd0);
    chk("fp_rsp_Out", f_rsp_Out, 32'd42);
    chk("fp_rsp_flags", 32'({f_rsp_zero, f_rsp_N, f_rsp_C, f_rsp_V}), 32'd0);
    f_req0_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!f_acc1 && n < 10);
    chk("fp_port1_after_drop", 32'(f_acc1), 32'd1);
    f_req1_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("fp_rsp_id", 32'(f_rsp_id), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
